// File: rtl/dma_pkg.sv
// Shared types, bus encodings and default sizes for the DMA bus master.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W  = 16;
    localparam int unsigned DMA_DATA_W  = 32;
    localparam int unsigned DMA_LEN_W   = 16;
    localparam int unsigned DMA_TIMEOUT = 64;

    localparam logic CTRL_READ  = 1'b0;
    localparam logic CTRL_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_REQ,
        RD_ACK,
        WR_SETUP,
        WR_REQ,
        WR_ACK
    } dma_state_e;

    // Bus phase of the single transfer currently on the bus.
    typedef enum logic [1:0] {
        XP_IDLE,
        XP_SETUP,
        XP_REQ,
        XP_ACK
    } xfer_phase_e;

endpackage

// File: rtl/dma_bus_master_if.sv
// Shared initiator/target bus. Data/address/control/strobe are resolved nets
// because several agents take turns driving them.
interface dma_bus_master_if
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned DATA_W = DMA_DATA_W
);

    wire [DATA_W-1:0] Data_Bus;
    wire [ADDR_W-1:0] Address_Bus;
    wire              Control;
    wire              IReady;
    logic             TReady;

    modport master (
        inout Data_Bus,
        inout Address_Bus,
        inout Control,
        inout IReady,
        input TReady
    );

    modport slave (
        inout  Data_Bus,
        input  Address_Bus,
        input  Control,
        input  IReady,
        output TReady
    );

endinterface

// File: rtl/dma_bus_xfer.sv
// One setup/req/ack bus transfer: drives the bus for the phase chosen by the
// sequencer, reports when that phase's handshake condition is met, times out
// stalled REQ/ACK phases and holds the word captured on a read.
module dma_bus_xfer
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W  = DMA_ADDR_W,
    parameter int unsigned DATA_W  = DMA_DATA_W,
    parameter int unsigned TIMEOUT = DMA_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  xfer_phase_e       phase,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              step,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic [DATA_W-1:0] rdata,
    dma_bus_master_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    // Handshake condition per phase; SETUP also waits out a lingering TReady.
    always_comb begin
        waiting   = (phase == XP_REQ) || (phase == XP_ACK);
        step      = 1'b0;
        unique case (phase)
            XP_SETUP: step = !bus.TReady;
            XP_REQ:   step = bus.TReady;
            XP_ACK:   step = !bus.TReady;
            default:  step = 1'b0;
        endcase
        xfer_done = (phase == XP_ACK) && step;
        xfer_err  = waiting && !step && (wait_cnt == LAST_WAIT);
    end

    // Every REQ/ACK is entered through a met step, so clearing on step
    // restarts the wait budget for each waiting phase.
    always_ff @(posedge clk) begin
        if (rst || !waiting || step) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Holding register: read data is taken on the TReady rise of a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if ((phase == XP_REQ) && (write == CTRL_READ) && bus.TReady) begin
            rdata <= bus.Data_Bus;
        end
    end

    assign bus.Address_Bus = (phase != XP_IDLE) ? addr : 'z;
    assign bus.Control     = (phase != XP_IDLE) ? write : 1'bz;
    assign bus.IReady      = (phase != XP_IDLE) ? (phase == XP_REQ) : 1'bz;
    assign bus.Data_Bus    = ((phase != XP_IDLE) && (write == CTRL_WRITE)) ? wdata : 'z;

endmodule

// File: rtl/dma_bus_master.sv
// Word-by-word memory-to-memory copy engine: sequences read/write transfers
// through dma_bus_xfer and walks the source/destination addresses.
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W  = DMA_ADDR_W,
    parameter int unsigned DATA_W  = DMA_DATA_W,
    parameter int unsigned LEN_W   = DMA_LEN_W,
    parameter int unsigned TIMEOUT = DMA_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    dma_bus_master_if.master  bus
);

    dma_state_e        state, state_n;
    xfer_phase_e       phase;
    logic              xfer_write;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic              done_q, err_q;
    logic              accept, zero_len, word_end, abort, last_word;
    logic              step, xfer_done, xfer_err;
    logic [DATA_W-1:0] hold_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, bus phase for the transfer engine, and datapath strobes.
    always_comb begin
        state_n    = state;
        phase      = XP_IDLE;
        xfer_write = CTRL_READ;
        accept     = 1'b0;
        zero_len   = 1'b0;
        word_end   = 1'b0;
        abort      = 1'b0;
        last_word  = (rem_q == LEN_W'(1));
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        accept  = 1'b1;
                        state_n = RD_SETUP;
                    end else begin
                        zero_len = 1'b1;
                    end
                end
            end
            RD_SETUP: begin
                phase = XP_SETUP;
                if (step) state_n = RD_REQ;
            end
            RD_REQ: begin
                phase = XP_REQ;
                if (step) state_n = RD_ACK;
            end
            RD_ACK: begin
                phase = XP_ACK;
                if (xfer_done) state_n = WR_SETUP;
            end
            WR_SETUP: begin
                phase      = XP_SETUP;
                xfer_write = CTRL_WRITE;
                if (step) state_n = WR_REQ;
            end
            WR_REQ: begin
                phase      = XP_REQ;
                xfer_write = CTRL_WRITE;
                if (step) state_n = WR_ACK;
            end
            WR_ACK: begin
                phase      = XP_ACK;
                xfer_write = CTRL_WRITE;
                if (xfer_done) begin
                    word_end = 1'b1;
                    state_n  = last_word ? IDLE : RD_SETUP;
                end
            end
            default: state_n = IDLE;
        endcase
        if (xfer_err) begin
            abort   = 1'b1;
            state_n = IDLE;
        end
    end

    // Address/count registers and the done/error flags. A zero-length start
    // also clears error so done and error can never be high together.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= zero_len || (word_end && last_word);
            if (accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                rem_q <= length;
                err_q <= 1'b0;
            end
            if (zero_len) begin
                err_q <= 1'b0;
            end
            if (word_end) begin
                src_q <= src_q + ADDR_W'(1);
                dst_q <= dst_q + ADDR_W'(1);
                rem_q <= rem_q - LEN_W'(1);
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign done  = done_q;
    assign error = err_q;

    dma_bus_xfer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .write     (xfer_write),
        .addr      ((xfer_write == CTRL_WRITE) ? dst_q : src_q),
        .wdata     (hold_data),
        .step      (step),
        .xfer_done (xfer_done),
        .xfer_err  (xfer_err),
        .rdata     (hold_data),
        .bus       (bus)
    );

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master with a zero-wait memory target at 0-31
// (mem[i] = 3*i) plus one extra word at 0xFFFF.
module tb_dma_bus_master;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] src_addr, dst_addr;
    logic [15:0] length;
    logic        busy, done, error;

    // Target model state
    logic [31:0] mem [32];
    logic [31:0] mem_hi;
    logic        mem_init;
    logic        park;
    logic        stall_en;
    logic [15:0] stall_addr;
    logic        t_ready;
    logic        rd_drive;
    logic [31:0] rd_word;

    // Monitor accumulators (only ever increase)
    int          n_busy, n_done, n_both, n_rd, n_wr;
    logic [15:0] rd_log [16];
    logic [15:0] wr_log [16];

    int n_vec = 0;
    int n_bad = 0;

    dma_bus_master_if #(.ADDR_W(16), .DATA_W(32)) ifc ();

    dma_bus_master #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .LEN_W   (16),
        .TIMEOUT (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .bus      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait target: TReady follows IReady for mapped addresses.
    always_comb begin
        t_ready = (ifc.IReady === 1'b1)
               && (((ifc.Address_Bus < 16'd32) === 1'b1) || (ifc.Address_Bus === 16'hFFFF))
               && !(stall_en && (ifc.Control === 1'b1) && (ifc.Address_Bus === stall_addr));
        rd_drive = t_ready && (ifc.Control === 1'b0);
        rd_word  = (ifc.Address_Bus === 16'hFFFF) ? mem_hi : mem[ifc.Address_Bus[4:0]];
    end

    assign ifc.TReady      = t_ready;
    assign ifc.Data_Bus    = rd_drive ? rd_word : 'z;
    // Parking driver: another agent holding the idle bus at zero.
    assign ifc.Data_Bus    = park ? 32'h0 : 'z;
    assign ifc.Address_Bus = park ? 16'h0 : 'z;
    assign ifc.Control     = park ? 1'b0 : 1'bz;
    assign ifc.IReady      = park ? 1'b0 : 1'bz;

    // Target write port and memory initialisation.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(3 * i);
            mem_hi <= 32'hCAFE_F00D;
        end else if (t_ready && (ifc.Control === 1'b1)) begin
            if (ifc.Address_Bus === 16'hFFFF) mem_hi <= ifc.Data_Bus;
            else mem[ifc.Address_Bus[4:0]] <= ifc.Data_Bus;
        end
    end

    // Bus/flag monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (busy === 1'b1) n_busy++;
        if (done === 1'b1) n_done++;
        if ((done === 1'b1) && (error === 1'b1)) n_both++;
        if ((ifc.IReady === 1'b1) && t_ready) begin
            if (ifc.Control === 1'b0) begin
                rd_log[n_rd % 16] = ifc.Address_Bus;
                n_rd++;
            end else begin
                wr_log[n_wr % 16] = ifc.Address_Bus;
                n_wr++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0) && (n < 300)) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        tick();
    endtask

    task automatic park_check(input string tag);
        park = 1'b1;
        #1;
        chk({tag, "_addr_z"}, 64'(ifc.Address_Bus), 64'd0);
        chk({tag, "_data_z"}, 64'(ifc.Data_Bus), 64'd0);
        chk({tag, "_ctrl_z"}, 64'(ifc.Control), 64'd0);
        chk({tag, "_irdy_z"}, 64'(ifc.IReady), 64'd0);
        park = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_busy, b_done, b_rd, b_wr, k;

        rst = 1'b1; start = 1'b0; park = 1'b0; stall_en = 1'b0; stall_addr = 16'h0;
        mem_init = 1'b1; src_addr = '0; dst_addr = '0; length = '0;
        n_busy = 0; n_done = 0; n_both = 0; n_rd = 0; n_wr = 0;
        repeat (3) tick();
        mem_init = 1'b0;
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_error", 64'(error), 64'd0);
        rst = 1'b0;
        tick();

        // Basic 3-word copy 2..4 -> 20..22
        b_busy = n_busy; b_done = n_done; b_rd = n_rd; b_wr = n_wr;
        do_start(16'd2, 16'd20, 16'd3);
        wait_idle("copy");
        chk("copy_m20", 64'(mem[20]), 64'd6);
        chk("copy_m21", 64'(mem[21]), 64'd9);
        chk("copy_m22", 64'(mem[22]), 64'd12);
        chk("copy_rd_cnt", 64'(n_rd - b_rd), 64'd3);
        chk("copy_wr_cnt", 64'(n_wr - b_wr), 64'd3);
        chk("copy_busy_cyc", 64'(n_busy - b_busy), 64'd18);
        chk("copy_done_cnt", 64'(n_done - b_done), 64'd1);
        chk("copy_error", 64'(error), 64'd0);
        chk("copy_rd_a0", 64'(rd_log[(b_rd + 0) % 16]), 64'd2);
        chk("copy_rd_a2", 64'(rd_log[(b_rd + 2) % 16]), 64'd4);
        chk("copy_wr_a1", 64'(wr_log[(b_wr + 1) % 16]), 64'd21);
        park_check("copy_after");

        // Zero-length start: done next cycle, no bus activity
        park = 1'b1;
        b_busy = n_busy; b_rd = n_rd; b_wr = n_wr;
        do_start(16'd7, 16'd9, 16'd0);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_addr_z", 64'(ifc.Address_Bus), 64'd0);
        chk("len0_irdy_z", 64'(ifc.IReady), 64'd0);
        tick();
        chk("len0_done_pulse", 64'(done), 64'd0);
        chk("len0_busy_cyc", 64'(n_busy - b_busy), 64'd0);
        chk("len0_bus_cnt", 64'((n_rd - b_rd) + (n_wr - b_wr)), 64'd0);
        chk("len0_m9", 64'(mem[9]), 64'd27);
        park = 1'b0;
        tick();

        // Unmapped source: timeout after 64 cycles in RD_REQ
        b_busy = n_busy; b_done = n_done; b_rd = n_rd;
        do_start(16'd100, 16'd5, 16'd1);
        wait_idle("tmo");
        chk("tmo_error", 64'(error), 64'd1);
        chk("tmo_busy_cyc", 64'(n_busy - b_busy), 64'd65);
        chk("tmo_done_cnt", 64'(n_done - b_done), 64'd0);
        chk("tmo_rd_cnt", 64'(n_rd - b_rd), 64'd0);
        chk("tmo_m5", 64'(mem[5]), 64'd15);
        park_check("tmo_after");
        tick();
        chk("tmo_error_sticky", 64'(error), 64'd1);
        b_done = n_done;
        do_start(16'd1, 16'd30, 16'd1);
        chk("tmo_clear", 64'(error), 64'd0);
        wait_idle("recov");
        chk("recov_m30", 64'(mem[30]), 64'd3);
        chk("recov_done_cnt", 64'(n_done - b_done), 64'd1);

        // Start while busy is ignored
        b_busy = n_busy; b_done = n_done; b_wr = n_wr;
        do_start(16'd5, 16'd28, 16'd2);
        repeat (3) tick();
        src_addr = 16'd10; dst_addr = 16'd0; length = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("ign");
        chk("ign_m28", 64'(mem[28]), 64'd15);
        chk("ign_m29", 64'(mem[29]), 64'd18);
        chk("ign_m0", 64'(mem[0]), 64'd0);
        chk("ign_busy_cyc", 64'(n_busy - b_busy), 64'd12);
        chk("ign_wr_cnt", 64'(n_wr - b_wr), 64'd2);
        chk("ign_done_cnt", 64'(n_done - b_done), 64'd1);

        // Reset while in WR_REQ of word 2 (target stalls that write)
        stall_addr = 16'd25; stall_en = 1'b1;
        b_done = n_done; b_wr = n_wr;
        do_start(16'd4, 16'd24, 16'd4);
        k = 0;
        while (!((ifc.IReady === 1'b1) && (ifc.Control === 1'b1) && (ifc.Address_Bus === 16'd25)) && (k < 100)) begin
            tick();
            k++;
        end
        chk("rst_reach_wr2", 64'(ifc.Address_Bus), 64'd25);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        park_check("mid_rst");
        rst = 1'b0;
        stall_en = 1'b0;
        repeat (3) tick();
        chk("mid_rst_m24", 64'(mem[24]), 64'd12);
        chk("mid_rst_m25", 64'(mem[25]), 64'd75);
        chk("mid_rst_wr_cnt", 64'(n_wr - b_wr), 64'd1);
        chk("mid_rst_done_cnt", 64'(n_done - b_done), 64'd0);
        chk("mid_rst_busy_after", 64'(busy), 64'd0);

        // Address wrap 0xFFFF -> 0x0000
        b_done = n_done; b_rd = n_rd; b_wr = n_wr;
        do_start(16'hFFFF, 16'd0, 16'd2);
        wait_idle("wrap");
        chk("wrap_rd_a0", 64'(rd_log[(b_rd + 0) % 16]), 64'hFFFF);
        chk("wrap_rd_a1", 64'(rd_log[(b_rd + 1) % 16]), 64'h0000);
        chk("wrap_wr_a0", 64'(wr_log[(b_wr + 0) % 16]), 64'd0);
        chk("wrap_wr_a1", 64'(wr_log[(b_wr + 1) % 16]), 64'd1);
        chk("wrap_m0", 64'(mem[0]), 64'hCAFE_F00D);
        chk("wrap_m1", 64'(mem[1]), 64'hCAFE_F00D);
        chk("wrap_done_cnt", 64'(n_done - b_done), 64'd1);
        chk("wrap_error", 64'(error), 64'd0);

        chk("done_error_overlap", 64'(n_both), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
